// File: rtl/ita_step_scheduler_if.sv
// Job bus between the step scheduler and the matmul/softmax/requant datapath.
interface ita_step_scheduler_if #(
  parameter int unsigned CntWidth = 16
);
  logic                job_valid_o;
  logic                job_ready_i;
  logic [3:0]          step_o;
  logic [2:0]          requant_idx_o;
  logic [CntWidth-1:0] row_o;
  logic [CntWidth-1:0] col_o;
  logic [CntWidth-1:0] inner_o;
  logic                first_inner_o;
  logic                last_inner_o;
  logic                step_done_i;

  modport master (
    output job_valid_o, step_o, requant_idx_o, row_o, col_o, inner_o,
           first_inner_o, last_inner_o,
    input  job_ready_i, step_done_i
  );

  modport slave (
    input  job_valid_o, step_o, requant_idx_o, row_o, col_o, inner_o,
           first_inner_o, last_inner_o,
    output job_ready_i, step_done_i
  );
endinterface

// File: rtl/ita_step_scheduler.sv
// Walks the per-layer step list and issues row/col/inner tile jobs over valid/ready.
module ita_step_scheduler #(
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [1:0]          layer_i,
  input  logic [CntWidth-1:0] tile_s_i,
  input  logic [CntWidth-1:0] tile_e_i,
  input  logic [CntWidth-1:0] tile_p_i,
  input  logic [CntWidth-1:0] tile_f_i,
  output logic                busy_o,
  output logic                done_o,
  ita_step_scheduler_if.master job_if
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_e;
  typedef enum logic [1:0] {L_ATTN = 2'd0, L_FF = 2'd1, L_LIN = 2'd2, L_SATTN = 2'd3} layer_e;
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_Q = 4'd1, S_K = 4'd2, S_V = 4'd3, S_QK = 4'd4, S_AV = 4'd5,
    S_OW = 4'd6, S_F1 = 4'd7, S_F2 = 4'd8, S_MM = 4'd9
  } step_e;

  localparam logic [CntWidth-1:0] One = CntWidth'(1);

  // Step list lookup; S_IDLE marks the end of the list.
  function automatic step_e step_at(layer_e l, logic [2:0] pos);
    step_at = S_IDLE;
    case (l)
      L_ATTN, L_SATTN: begin
        case (pos)
          3'd0: step_at = S_Q;
          3'd1: step_at = S_K;
          3'd2: step_at = S_V;
          3'd3: step_at = S_QK;
          3'd4: step_at = S_AV;
          3'd5: step_at = (l == L_ATTN) ? S_OW : S_IDLE;
          default: step_at = S_IDLE;
        endcase
      end
      L_FF: begin
        if (pos == 3'd0)      step_at = S_F1;
        else if (pos == 3'd1) step_at = S_F2;
      end
      default: if (pos == 3'd0) step_at = S_MM;
    endcase
  endfunction

  function automatic logic [CntWidth-1:0] bound_col(step_e st, logic [CntWidth-1:0] s,
      logic [CntWidth-1:0] e, logic [CntWidth-1:0] p, logic [CntWidth-1:0] f);
    case (st)
      S_Q, S_K, S_V, S_AV: bound_col = p;
      S_QK:                bound_col = s;
      S_OW, S_F2:          bound_col = e;
      S_F1, S_MM:          bound_col = f;
      default:             bound_col = One;
    endcase
  endfunction

  function automatic logic [CntWidth-1:0] bound_inner(step_e st, logic [CntWidth-1:0] s,
      logic [CntWidth-1:0] e, logic [CntWidth-1:0] p, logic [CntWidth-1:0] f);
    case (st)
      S_Q, S_K, S_V, S_F1, S_MM: bound_inner = e;
      S_QK, S_OW:                bound_inner = p;
      S_AV:                      bound_inner = s;
      S_F2:                      bound_inner = f;
      default:                   bound_inner = One;
    endcase
  endfunction

  function automatic logic [2:0] requant_of(step_e st);
    case (st)
      S_K:        requant_of = 3'd1;
      S_V:        requant_of = 3'd2;
      S_QK:       requant_of = 3'd3;
      S_AV:       requant_of = 3'd4;
      S_OW:       requant_of = 3'd5;
      S_F1, S_MM: requant_of = 3'd6;
      S_F2:       requant_of = 3'd7;
      default:    requant_of = 3'd0;
    endcase
  endfunction

  function automatic logic [CntWidth-1:0] clamp1(logic [CntWidth-1:0] x);
    clamp1 = (x == '0) ? One : x;
  endfunction

  state_e              r_state, w_nxt_state;
  layer_e              r_layer;
  logic [2:0]          r_pos, w_nxt_pos;
  logic [CntWidth-1:0] r_s, r_e, r_p, r_f;
  step_e               r_step, w_nxt_step;
  logic [CntWidth-1:0] r_row, r_col, r_inner, w_nxt_row, w_nxt_col, w_nxt_inner;
  logic                r_valid, r_busy, r_done, r_first, r_last;
  logic [2:0]          r_rq;
  logic                w_nxt_valid, w_nxt_busy, w_nxt_done, w_latch;
  layer_e              w_layer;
  logic [CntWidth-1:0] w_s, w_e, w_p, w_f, w_cb, w_ib, w_nib;
  step_e               w_step2;

  // Effective configuration: live (clamped) inputs while idle, latched copy otherwise.
  always_comb begin
    w_layer = (r_state == ST_IDLE) ? layer_e'(layer_i) : r_layer;
    w_s     = (r_state == ST_IDLE) ? clamp1(tile_s_i) : r_s;
    w_e     = (r_state == ST_IDLE) ? clamp1(tile_e_i) : r_e;
    w_p     = (r_state == ST_IDLE) ? clamp1(tile_p_i) : r_p;
    w_f     = (r_state == ST_IDLE) ? clamp1(tile_f_i) : r_f;
    w_cb    = bound_col(r_step, w_s, w_e, w_p, w_f);
    w_ib    = bound_inner(r_step, w_s, w_e, w_p, w_f);
    w_step2 = step_at(w_layer, r_pos + 3'd1);
  end

  // Next-state and next-output logic; abort overrides everything.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pos   = r_pos;
    w_nxt_step  = r_step;
    w_nxt_row   = r_row;
    w_nxt_col   = r_col;
    w_nxt_inner = r_inner;
    w_nxt_valid = r_valid;
    w_nxt_busy  = r_busy;
    w_nxt_done  = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_latch     = 1'b1;
          w_nxt_state = ST_ISSUE;
          w_nxt_pos   = 3'd0;
          w_nxt_step  = step_at(w_layer, 3'd0);
          w_nxt_row   = '0;
          w_nxt_col   = '0;
          w_nxt_inner = '0;
          w_nxt_valid = 1'b1;
          w_nxt_busy  = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (r_valid && job_if.job_ready_i) begin
          if (r_inner != w_ib - One) begin
            w_nxt_inner = r_inner + One;
          end else begin
            w_nxt_inner = '0;
            if (r_col != w_cb - One) begin
              w_nxt_col = r_col + One;
            end else if (r_row != w_s - One) begin
              w_nxt_col = '0;
              w_nxt_row = r_row + One;
            end else begin
              w_nxt_inner = r_inner;
              w_nxt_valid = 1'b0;
              w_nxt_state = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        if (job_if.step_done_i) begin
          w_nxt_row   = '0;
          w_nxt_col   = '0;
          w_nxt_inner = '0;
          if (w_step2 == S_IDLE) begin
            w_nxt_state = ST_DONE;
            w_nxt_step  = S_IDLE;
            w_nxt_done  = 1'b1;
          end else begin
            w_nxt_state = ST_ISSUE;
            w_nxt_pos   = r_pos + 3'd1;
            w_nxt_step  = w_step2;
            w_nxt_valid = 1'b1;
          end
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_busy  = 1'b0;
      end
    endcase
    if (abort_i) begin
      w_nxt_state = ST_IDLE;
      w_nxt_pos   = 3'd0;
      w_nxt_step  = S_IDLE;
      w_nxt_row   = '0;
      w_nxt_col   = '0;
      w_nxt_inner = '0;
      w_nxt_valid = 1'b0;
      w_nxt_busy  = 1'b0;
      w_nxt_done  = 1'b0;
      w_latch     = 1'b0;
    end
    w_nib = bound_inner(w_nxt_step, w_s, w_e, w_p, w_f);
  end

  // State, configuration and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_layer <= L_ATTN;
      r_pos   <= 3'd0;
      r_s     <= One;
      r_e     <= One;
      r_p     <= One;
      r_f     <= One;
      r_step  <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_inner <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_rq    <= 3'd0;
    end else begin
      r_state <= w_nxt_state;
      r_pos   <= w_nxt_pos;
      r_step  <= w_nxt_step;
      r_row   <= w_nxt_row;
      r_col   <= w_nxt_col;
      r_inner <= w_nxt_inner;
      r_valid <= w_nxt_valid;
      r_busy  <= w_nxt_busy;
      r_done  <= w_nxt_done;
      r_first <= w_nxt_valid && (w_nxt_inner == '0);
      r_last  <= w_nxt_valid && (w_nxt_inner == w_nib - One);
      r_rq    <= requant_of(w_nxt_step);
      if (w_latch) begin
        r_layer <= w_layer;
        r_s     <= w_s;
        r_e     <= w_e;
        r_p     <= w_p;
        r_f     <= w_f;
      end
    end
  end

  assign job_if.job_valid_o   = r_valid;
  assign job_if.step_o        = r_step;
  assign job_if.requant_idx_o = r_rq;
  assign job_if.row_o         = r_row;
  assign job_if.col_o         = r_col;
  assign job_if.inner_o       = r_inner;
  assign job_if.first_inner_o = r_first;
  assign job_if.last_inner_o  = r_last;
  assign busy_o               = r_busy;
  assign done_o               = r_done;

endmodule

// File: tb/tb_ita_step_scheduler.sv
// Scoreboard bench for ita_step_scheduler: expected jobs queued at start, popped on transfer.
module tb_ita_step_scheduler;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst, start, abort, ready, step_done;
  logic [1:0]    layer;
  logic [CW-1:0] ts, te, tp, tf;
  logic          busy, done;

  ita_step_scheduler_if #(.CntWidth(CW)) jif ();
  assign jif.job_ready_i = ready;
  assign jif.step_done_i = step_done;

  ita_step_scheduler #(.CntWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .layer_i(layer),
    .tile_s_i(ts), .tile_e_i(te), .tile_p_i(tp), .tile_f_i(tf),
    .busy_o(busy), .done_o(done), .job_if(jif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    step;
    logic [2:0]    rq;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic [CW-1:0] inner;
    logic          first;
    logic          last;
    logic          eos;
  } job_t;

  job_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   g_jobs, g_dones;

  function automatic int list_len(int l);
    case (l)
      0: return 6;
      1: return 2;
      2: return 1;
      default: return 5;
    endcase
  endfunction

  function automatic logic [3:0] list_step(int l, int k);
    case (l)
      1: return (k == 0) ? 4'd7 : 4'd8;
      2: return 4'd9;
      default: return 4'(k + 1);
    endcase
  endfunction

  function automatic logic [2:0] rq_of(logic [3:0] st);
    if (st == 4'd9) return 3'd6;
    return 3'(st - 4'd1);
  endfunction

  // Spec model of the loop nest for every step of the layer.
  task automatic build_expected(input int l, input int s0, input int e0, input int p0, input int f0);
    int s, e, p, f, cb, ib;
    job_t j;
    s = (s0 == 0) ? 1 : s0;
    e = (e0 == 0) ? 1 : e0;
    p = (p0 == 0) ? 1 : p0;
    f = (f0 == 0) ? 1 : f0;
    exp_q.delete();
    for (int k = 0; k < list_len(l); k++) begin
      j.step = list_step(l, k);
      j.rq   = rq_of(j.step);
      case (j.step)
        4'd1, 4'd2, 4'd3: begin cb = p; ib = e; end
        4'd4:             begin cb = s; ib = p; end
        4'd5:             begin cb = p; ib = s; end
        4'd6:             begin cb = e; ib = p; end
        4'd8:             begin cb = e; ib = f; end
        default:          begin cb = f; ib = e; end
      endcase
      for (int r = 0; r < s; r++)
        for (int c = 0; c < cb; c++)
          for (int i = 0; i < ib; i++) begin
            j.row   = CW'(r);
            j.col   = CW'(c);
            j.inner = CW'(i);
            j.first = (i == 0);
            j.last  = (i == ib - 1);
            j.eos   = (r == s - 1) && (c == cb - 1) && (i == ib - 1);
            exp_q.push_back(j);
          end
    end
  endtask

  // Drives one layer invocation and scores every transferred job against the queue.
  task automatic run_layer(input logic [1:0] l, input int s, input int e, input int p, input int f,
                           input bit toggle, input bit spurious, input int abort_after);
    job_t cur, held, ej;
    int   jobs = 0, dones = 0, tcnt = 0, wait_cnt = -1;
    bit   prev_stall = 0, finished = 0, done_seen = 0, aborted = 0, rdy;
    build_expected(int'(l), s, e, p, f);
    @(negedge clk);
    layer = l; ts = CW'(s); te = CW'(e); tp = CW'(p); tf = CW'(f);
    start = 1'b1;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; ready = 1'b0; step_done = 1'b0;
      cur = '{step: jif.step_o, rq: jif.requant_idx_o, row: jif.row_o, col: jif.col_o,
              inner: jif.inner_o, first: jif.first_inner_o, last: jif.last_inner_o, eos: 1'b0};
      if (aborted) begin
        n_checks++;
        if ({jif.job_valid_o, cur, busy, done} !== '0) begin
          $display("FAIL abort_reset: got valid=%b job=%h busy=%b done=%b, want all zero",
                   jif.job_valid_o, cur, busy, done);
        end else n_pass++;
        finished = 1;
        continue;
      end
      if (cyc == 0) begin
        n_checks++;
        if ({jif.job_valid_o, busy} !== 2'b11)
          $display("FAIL start_latency: valid=%b busy=%b, want 1 1", jif.job_valid_o, busy);
        else n_pass++;
      end
      if (cyc == 2) start = 1'b1;
      if (done_seen) begin
        n_checks++;
        if ({busy, done, jif.job_valid_o} !== 3'b000)
          $display("FAIL post_done: busy=%b done=%b valid=%b, want 0 0 0", busy, done, jif.job_valid_o);
        else n_pass++;
        finished = 1;
        continue;
      end
      if (done) begin
        dones++;
        done_seen = 1;
        n_checks++;
        if (busy !== 1'b1 || jif.job_valid_o !== 1'b0)
          $display("FAIL done_busy: busy=%b valid=%b, want 1 0", busy, jif.job_valid_o);
        else n_pass++;
      end
      if (wait_cnt >= 0) begin
        n_checks++;
        if (jif.job_valid_o !== 1'b0)
          $display("FAIL wait_valid: valid=%b, want 0 while waiting for step_done", jif.job_valid_o);
        else n_pass++;
        if (wait_cnt == 0) step_done = 1'b1;
        wait_cnt--;
      end
      if (prev_stall) begin
        n_checks++;
        if (jif.job_valid_o !== 1'b1 || cur !== held)
          $display("FAIL stall_hold: valid=%b job=%h, want 1 %h", jif.job_valid_o, cur, held);
        else n_pass++;
      end
      prev_stall = 0;
      if (jif.job_valid_o === 1'b1) begin
        rdy = toggle ? (tcnt % 3 == 0) : 1'b1;
        tcnt++;
        ready = rdy;
        held = cur;
        prev_stall = !rdy;
        if (rdy) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL extra_job: got job %h, want none", cur);
          end else begin
            ej = exp_q.pop_front();
            if (cur !== {ej[$bits(job_t)-1:1], 1'b0})
              $display("FAIL job%0d: got step=%0d rq=%0d r=%0d c=%0d i=%0d f=%b l=%b want step=%0d rq=%0d r=%0d c=%0d i=%0d f=%b l=%b",
                       jobs, cur.step, cur.rq, cur.row, cur.col, cur.inner, cur.first, cur.last,
                       ej.step, ej.rq, ej.row, ej.col, ej.inner, ej.first, ej.last);
            else n_pass++;
            if (spurious && ej.row == 0 && ej.col == 0 && ej.inner == 0) step_done = 1'b1;
            if (ej.eos) wait_cnt = spurious ? 2 : 0;
          end
          jobs++;
          if (abort_after != 0 && jobs == abort_after) begin
            abort = 1'b1;
            aborted = 1;
          end
        end
      end
    end
    n_checks++;
    if (!finished) $display("FAIL timeout: layer %0d did not complete, got %0d jobs", l, jobs);
    else n_pass++;
    if (abort_after == 0) begin
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL missing_jobs: got %0d left over, want 0", exp_q.size());
      else n_pass++;
    end
    exp_q.delete();
    g_jobs  = jobs;
    g_dones = dones;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; ready = 1'b0; step_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0; step_done = 1'b0;
    layer = 2'd0; ts = '0; te = '0; tp = '0; tf = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({jif.job_valid_o, jif.step_o, jif.requant_idx_o, jif.row_o, jif.col_o, jif.inner_o,
         jif.first_inner_o, jif.last_inner_o, busy, done} !== '0)
      $display("FAIL reset: got valid=%b step=%0d busy=%b done=%b, want all zero",
               jif.job_valid_o, jif.step_o, busy, done);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_attention();
    run_layer(2'd0, 1, 1, 1, 1, 1'b0, 1'b0, 0);
    n_checks++;
    if (g_jobs != 6 || g_dones != 1)
      $display("FAIL attention_count: got jobs=%0d dones=%0d, want 6 1", g_jobs, g_dones);
    else n_pass++;
  endtask

  task automatic test_feedforward();
    run_layer(2'd1, 2, 1, 1, 3, 1'b0, 1'b0, 0);
    n_checks++;
    if (g_jobs != 12 || g_dones != 1)
      $display("FAIL ff_count: got jobs=%0d dones=%0d, want 12 1", g_jobs, g_dones);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    run_layer(2'd2, 1, 4, 1, 1, 1'b1, 1'b0, 0);
    n_checks++;
    if (g_jobs != 4 || g_dones != 1)
      $display("FAIL bp_count: got jobs=%0d dones=%0d, want 4 1", g_jobs, g_dones);
    else n_pass++;
  endtask

  task automatic test_zero_clamp();
    run_layer(2'd3, 0, 0, 0, 0, 1'b0, 1'b0, 0);
    n_checks++;
    if (g_jobs != 5 || g_dones != 1)
      $display("FAIL clamp_count: got jobs=%0d dones=%0d, want 5 1", g_jobs, g_dones);
    else n_pass++;
  endtask

  task automatic test_abort();
    // Q, K, V are 4 jobs each at S=2,E=1,P=2; abort lands on the 2nd QK job.
    run_layer(2'd0, 2, 1, 2, 1, 1'b0, 1'b0, 14);
    n_checks++;
    if (g_jobs != 14 || g_dones != 0)
      $display("FAIL abort_count: got jobs=%0d dones=%0d, want 14 0", g_jobs, g_dones);
    else n_pass++;
    run_layer(2'd0, 1, 1, 1, 1, 1'b0, 1'b0, 0);
    n_checks++;
    if (g_jobs != 6 || g_dones != 1)
      $display("FAIL restart_count: got jobs=%0d dones=%0d, want 6 1", g_jobs, g_dones);
    else n_pass++;
  endtask

  task automatic test_spurious_done();
    run_layer(2'd0, 1, 2, 1, 1, 1'b0, 1'b1, 0);
    n_checks++;
    if (g_jobs != 10 || g_dones != 1)
      $display("FAIL spurious_count: got jobs=%0d dones=%0d, want 10 1", g_jobs, g_dones);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_attention();
    test_feedforward();
    test_backpressure();
    test_zero_clamp();
    test_abort();
    test_spurious_done();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
